alu_muldiv: RTL and testbench
=============================

# alu_muldiv

Parametrised, handshaked ALU for the multi-cycle RV32E core, adding the RISC-V M extension to the base integer operations. Base operations complete in one cycle through a registered result. MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU run on an iterative radix-2 engine. The block sits in the execute stage, and the core's control FSM stalls on `in_ready`/`out_valid`.

## Interface
- `BIT_WIDTH`, 32: operand/result width; must be ≥ 4.
- `MULDIV_EN`, 1: 1 = M ops iterate; 0 = M ops return 0 with base-op latency.
- `clk`  in  1: clock, rising edge.
- `rst`  in  1: reset, asynchronous, active-high.
- `flush`  in  1: synchronous abort of any operation in flight.
- `in_valid`  in  1: request valid.
- `in_ready`  out  1: block can accept; high only in IDLE.
- `op`  in  5: operation code (`alu_pkg::alu_op_e`).
- `in1`, `in2`  in  BIT_WIDTH: operands (rs1, rs2).
- `out_valid`  out  1: result valid; held until accepted.
- `out_ready`  in  1: consumer takes result.
- `out`  out  BIT_WIDTH: result.

## Operation
- Opcodes 0x00–0x09 are the base ops:
  - ADD: in1+in2.
  - SUB: in1−in2.
  - SLT / SLTU: signed / unsigned in1<in2, result zero-extended.
  - AND, OR, XOR.
  - SLL, SRL, SRA: shift amount = in2[$clog2(BIT_WIDTH)-1:0].
- Opcodes 0x10–0x17 are the M ops: MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU.
- Any other opcode produces result 0 with base-op latency.
- State machine (`alu_state_e`): IDLE, CALC, FIX, DONE.
  - IDLE: `in_ready`=1. On accept (`in_valid`&`in_ready`), latch op and operands.
  - IDLE → DONE on accept for base ops, undefined opcodes, M ops when MULDIV_EN=0, and the special divide cases.
  - IDLE → CALC on accept for all other M ops.
  - CALC: BIT_WIDTH iterations, one per cycle, on operand magnitudes. Multiply is shift-add into a 2·BIT_WIDTH accumulator. Divide is restoring shift-subtract. The counter is $clog2(BIT_WIDTH)+1 bits wide.
  - CALC → FIX after the last iteration.
  - FIX: apply sign correction and select the high or low half. Quotient sign = sign(in1) XOR sign(in2). Remainder sign = sign(in1). FIX → DONE.
  - DONE: `out_valid`=1 and `out` stable. On `out_ready`, DONE → IDLE.
- Special divide cases, resolved without iterating:
  - Divide by zero: DIV/DIVU return all ones; REM/REMU return in1.
  - Signed overflow (in1 = most-negative, in2 = −1): DIV returns in1; REM returns 0.
- `flush` forces IDLE on the next edge from any state and drops `out_valid`. `flush` takes priority over accept and over `out_ready`.
- Changes to `in1`/`in2`/`op` after acceptance have no effect on the operation in flight.

## Timing
- Reset values: state IDLE, `in_ready`=1, `out_valid`=0, `out`=0, counter 0.
- Base op accepted at edge t: `out_valid`=1 in the cycle after t (1-cycle latency).
- Iterative M op accepted at edge t: CALC occupies edges t+1..t+BIT_WIDTH, FIX is entered at edge t+BIT_WIDTH, and `out_valid` rises after edge t+BIT_WIDTH+1. That is 33 cycles for BIT_WIDTH=32.
- Special-case divide: 1-cycle latency.
- No back-to-back issue. `in_ready` is low from acceptance until the edge where DONE & `out_ready` occurs. Maximum base-op throughput is 1 per 2 cycles.
- `in_ready` is a pure function of state, with no combinational path from any input.
- `rst` asserted mid-operation: immediately IDLE, outputs at reset values.
- `flush` and `out_ready` in the same DONE cycle: the result is dropped. The consumer must treat it as not delivered.

## Structure
- `alu_pkg` holds `alu_op_e` (5-bit opcode enum), `alu_state_e`, and helper functions for the special-case divide results.
- Sub-module `muldiv_iter` implements the iterative datapath. Its ports are `start`, `is_div`, magnitudes, `step`, and `hi`/`lo` outputs.
- The top level owns the FSM, the base-op datapath, sign pre/post-processing and the handshake.

## Test plan
- ADD 0x7FFFFFFF+1 → 0x80000000 one cycle after accept. SUB 5−7 → 0xFFFFFFFE. SRA 0x80000000>>>4 → 0xF8000000.
- MULH 0x80000000×0x80000000 → 0x40000000. MULHSU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFF. `out_valid` exactly 33 cycles after accept.
- DIV −7/2 → 0xFFFFFFFD and REM → 0xFFFFFFFF. DIVU 7/0 → 0xFFFFFFFF and REMU → 7, both 1-cycle latency.
- DIV 0x80000000/0xFFFFFFFF → 0x80000000 and REM → 0. Random signed/unsigned M ops are checked against a reference model, BIT_WIDTH 8 and 32.
- `out_ready` held low for 10 cycles in DONE: `out` and `out_valid` stay stable and `in_ready` stays 0. `flush` at CALC cycle 5: IDLE next edge, no `out_valid`.
- `rst` pulsed asynchronously mid-CALC: outputs reach reset values immediately. A following ADD 1+1 → 2 completes normally.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared types for the ALU / M-extension block: opcodes, FSM states and
// helpers that classify divide operations and their non-iterating results.
package alu_pkg;

  typedef enum logic [4:0] {
    OP_ADD    = 5'h00,
    OP_SUB    = 5'h01,
    OP_SLT    = 5'h02,
    OP_SLTU   = 5'h03,
    OP_AND    = 5'h04,
    OP_OR     = 5'h05,
    OP_XOR    = 5'h06,
    OP_SLL    = 5'h07,
    OP_SRL    = 5'h08,
    OP_SRA    = 5'h09,
    OP_MUL    = 5'h10,
    OP_MULH   = 5'h11,
    OP_MULHSU = 5'h12,
    OP_MULHU  = 5'h13,
    OP_DIV    = 5'h14,
    OP_DIVU   = 5'h15,
    OP_REM    = 5'h16,
    OP_REMU   = 5'h17
  } alu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CALC,
    ST_FIX,
    ST_DONE
  } alu_state_e;

  // Which fixed value a divide resolves to without iterating.
  typedef enum logic [1:0] {
    SP_NONE,
    SP_ONES,
    SP_IN1,
    SP_ZERO
  } div_special_e;

  // M-extension opcodes occupy 0x10..0x17.
  function automatic logic is_muldiv_op(input logic [4:0] op);
    return op[4:3] == 2'b10;
  endfunction

  // DIV/DIVU/REM/REMU: bit 2 set within the M group; bit 1 selects remainder,
  // bit 0 selects unsigned.
  function automatic logic is_div_op(input logic [4:0] op);
    return is_muldiv_op(op) && op[2];
  endfunction

  // Divide by zero and signed overflow are answered directly.
  function automatic div_special_e div_special(input logic [4:0] op,
                                               input logic       b_zero,
                                               input logic       ovf);
    if (!is_div_op(op)) return SP_NONE;
    if (b_zero) return op[1] ? SP_IN1 : SP_ONES;
    if (ovf && !op[0]) return op[1] ? SP_ZERO : SP_IN1;
    return SP_NONE;
  endfunction

endpackage

// File: rtl/muldiv_iter.sv
// Radix-2 iterative engine on unsigned magnitudes. Multiply is shift-add into
// {hi,lo} (lo starts as the multiplier); divide is restoring shift-subtract
// with lo holding dividend/quotient and hi the partial remainder.
module muldiv_iter #(
  parameter int BIT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 is_div,
  input  logic [BIT_WIDTH-1:0] a_mag,
  input  logic [BIT_WIDTH-1:0] b_mag,
  input  logic                 step,
  output logic [BIT_WIDTH-1:0] hi,
  output logic [BIT_WIDTH-1:0] lo
);

  logic [BIT_WIDTH-1:0] r_hi;
  logic [BIT_WIDTH-1:0] r_lo;
  logic [BIT_WIDTH-1:0] r_b;
  logic                 r_is_div;

  logic [BIT_WIDTH:0]   w_sum;
  logic [BIT_WIDTH:0]   w_shift;
  logic [BIT_WIDTH-1:0] w_diff;
  logic                 w_ge;

  assign w_sum   = {1'b0, r_hi} + {1'b0, r_b};
  assign w_shift = {r_hi, r_lo[BIT_WIDTH-1]};
  assign w_ge    = w_shift >= {1'b0, r_b};
  // Only taken when w_ge, so the true difference is below r_b and fits.
  assign w_diff  = w_shift[BIT_WIDTH-1:0] - r_b;

  assign hi = r_hi;
  assign lo = r_lo;

  // Load operands on start, then advance one bit per step.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hi     <= '0;
      r_lo     <= '0;
      r_b      <= '0;
      r_is_div <= 1'b0;
    end else if (start) begin
      r_hi     <= '0;
      r_lo     <= a_mag;
      r_b      <= b_mag;
      r_is_div <= is_div;
    end else if (step) begin
      if (r_is_div) begin
        r_hi <= w_ge ? w_diff : w_shift[BIT_WIDTH-1:0];
        r_lo <= {r_lo[BIT_WIDTH-2:0], w_ge};
      end else if (r_lo[0]) begin
        {r_hi, r_lo} <= {w_sum, r_lo[BIT_WIDTH-1:1]};
      end else begin
        {r_hi, r_lo} <= {1'b0, r_hi, r_lo[BIT_WIDTH-1:1]};
      end
    end
  end

endmodule

// File: rtl/alu_muldiv.sv
// Handshaked ALU with RISC-V M extension: single-cycle base ops through a
// registered result, iterative multiply/divide via muldiv_iter.
module alu_muldiv
  import alu_pkg::*;
#(
  parameter int BIT_WIDTH = 32,
  parameter bit MULDIV_EN = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [4:0]           op,
  input  logic [BIT_WIDTH-1:0] in1,
  input  logic [BIT_WIDTH-1:0] in2,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [BIT_WIDTH-1:0] out
);

  localparam int SHW = $clog2(BIT_WIDTH);
  localparam int CW  = SHW + 1;

  alu_state_e           r_state;
  alu_state_e           w_state_next;
  logic [CW-1:0]        r_cnt;
  logic [BIT_WIDTH-1:0] r_out;
  logic                 r_neg;
  logic                 r_sel_hi;
  logic                 r_is_div;

  logic                 w_accept;
  logic                 w_go_calc;
  logic                 w_start;
  logic                 w_step;
  logic [SHW-1:0]       w_shamt;
  logic [BIT_WIDTH-1:0] w_base_res;
  logic [BIT_WIDTH-1:0] w_acc_res;
  logic                 w_a_signed;
  logic                 w_b_signed;
  logic                 w_s1;
  logic                 w_s2;
  logic [BIT_WIDTH-1:0] w_a_mag;
  logic [BIT_WIDTH-1:0] w_b_mag;
  logic                 w_is_div;
  logic                 w_is_rem;
  logic                 w_neg;
  logic                 w_sel_hi;
  logic                 w_b_zero;
  logic                 w_ovf;
  div_special_e         w_special;
  logic [BIT_WIDTH-1:0] w_hi;
  logic [BIT_WIDTH-1:0] w_lo;
  logic [2*BIT_WIDTH-1:0] w_prod_adj;
  logic [BIT_WIDTH-1:0] w_div_sel;
  logic [BIT_WIDTH-1:0] w_fix_res;

  assign w_accept = in_valid && (r_state == ST_IDLE);
  assign w_shamt  = in2[SHW-1:0];

  // Sign pre-processing: operands are reduced to magnitudes for the engine.
  assign w_a_signed = (op == OP_MUL) || (op == OP_MULH) || (op == OP_MULHSU) ||
                      (op == OP_DIV) || (op == OP_REM);
  assign w_b_signed = (op == OP_MUL) || (op == OP_MULH) ||
                      (op == OP_DIV) || (op == OP_REM);
  assign w_s1       = w_a_signed && in1[BIT_WIDTH-1];
  assign w_s2       = w_b_signed && in2[BIT_WIDTH-1];
  assign w_a_mag    = w_s1 ? -in1 : in1;
  assign w_b_mag    = w_s2 ? -in2 : in2;
  assign w_is_div   = is_div_op(op);
  assign w_is_rem   = w_is_div && op[1];
  assign w_neg      = w_is_rem ? w_s1 : (w_s1 ^ w_s2);
  assign w_sel_hi   = w_is_div ? w_is_rem : (op[1:0] != 2'b00);
  assign w_b_zero   = (in2 == '0);
  assign w_ovf      = (in1 == {1'b1, {(BIT_WIDTH-1){1'b0}}}) && (in2 == '1);
  assign w_special  = div_special(op, w_b_zero, w_ovf);
  assign w_go_calc  = MULDIV_EN && is_muldiv_op(op) && (w_special == SP_NONE);
  assign w_start    = w_accept && w_go_calc && !flush;
  assign w_step     = (r_state == ST_CALC);

  muldiv_iter #(
    .BIT_WIDTH(BIT_WIDTH)
  ) u_iter (
    .clk   (clk),
    .rst   (rst),
    .start (w_start),
    .is_div(w_is_div),
    .a_mag (w_a_mag),
    .b_mag (w_b_mag),
    .step  (w_step),
    .hi    (w_hi),
    .lo    (w_lo)
  );

  // Single-cycle base operations; undefined opcodes fall through to zero.
  always_comb begin
    w_base_res = '0;
    case (op)
      OP_ADD:  w_base_res = in1 + in2;
      OP_SUB:  w_base_res = in1 - in2;
      OP_SLT:  w_base_res = {{(BIT_WIDTH-1){1'b0}}, $signed(in1) < $signed(in2)};
      OP_SLTU: w_base_res = {{(BIT_WIDTH-1){1'b0}}, in1 < in2};
      OP_AND:  w_base_res = in1 & in2;
      OP_OR:   w_base_res = in1 | in2;
      OP_XOR:  w_base_res = in1 ^ in2;
      OP_SLL:  w_base_res = in1 << w_shamt;
      OP_SRL:  w_base_res = in1 >> w_shamt;
      OP_SRA:  w_base_res = $unsigned($signed(in1) >>> w_shamt);
      default: w_base_res = '0;
    endcase
  end

  // Result captured at accept for everything that does not iterate.
  always_comb begin
    w_acc_res = w_base_res;
    if (is_muldiv_op(op)) begin
      w_acc_res = '0;
      if (MULDIV_EN) begin
        case (w_special)
          SP_ONES: w_acc_res = '1;
          SP_IN1:  w_acc_res = in1;
          default: w_acc_res = '0;
        endcase
      end
    end
  end

  // Sign post-processing and half selection after the last iteration.
  always_comb begin
    w_prod_adj = r_neg ? -{w_hi, w_lo} : {w_hi, w_lo};
    w_div_sel  = r_sel_hi ? w_hi : w_lo;
    if (r_neg) w_div_sel = -w_div_sel;
    if (r_is_div)
      w_fix_res = w_div_sel;
    else if (r_sel_hi)
      w_fix_res = w_prod_adj[2*BIT_WIDTH-1:BIT_WIDTH];
    else
      w_fix_res = w_prod_adj[BIT_WIDTH-1:0];
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_next;
  end

  // Next-state and handshake outputs; flush overrides every transition.
  always_comb begin
    w_state_next = r_state;
    in_ready     = 1'b0;
    out_valid    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) w_state_next = w_go_calc ? ST_CALC : ST_DONE;
      end
      ST_CALC: if (r_cnt == CW'(BIT_WIDTH - 1)) w_state_next = ST_FIX;
      ST_FIX:  w_state_next = ST_DONE;
      ST_DONE: begin
        out_valid = 1'b1;
        if (out_ready) w_state_next = ST_IDLE;
      end
      default: w_state_next = ST_IDLE;
    endcase
    if (flush) w_state_next = ST_IDLE;
  end

  // Iteration counter, latched post-processing controls and result register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt    <= '0;
      r_out    <= '0;
      r_neg    <= 1'b0;
      r_sel_hi <= 1'b0;
      r_is_div <= 1'b0;
    end else if (flush) begin
      r_cnt <= '0;
    end else begin
      case (r_state)
        ST_IDLE: if (w_accept) begin
          r_cnt    <= '0;
          r_neg    <= w_neg;
          r_sel_hi <= w_sel_hi;
          r_is_div <= w_is_div;
          if (!w_go_calc) r_out <= w_acc_res;
        end
        ST_CALC: r_cnt <= r_cnt + 1'b1;
        ST_FIX:  r_out <= w_fix_res;
        default: ;
      endcase
    end
  end

  assign out = r_out;

endmodule

// File: tb/tb_alu_muldiv.sv
// Randomised and directed bench for alu_muldiv at BIT_WIDTH 32 and 8, checked
// against an arithmetic reference model.
module tb_alu_muldiv;
  import alu_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [4:0]  op = '0;
  logic [31:0] in1 = '0;
  logic [31:0] in2 = '0;
  logic        in_ready;
  logic        out_valid;
  logic [31:0] dut_out;

  logic        flush8 = 1'b0;
  logic        in_valid8 = 1'b0;
  logic        out_ready8 = 1'b0;
  logic [4:0]  op8 = '0;
  logic [7:0]  in1_8 = '0;
  logic [7:0]  in2_8 = '0;
  logic        in_ready8;
  logic        out_valid8;
  logic [7:0]  out8;

  int vectors = 0;
  int miscompares = 0;

  alu_muldiv #(.BIT_WIDTH(32), .MULDIV_EN(1'b1)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .in1(in1), .in2(in2), .out_valid(out_valid), .out_ready(out_ready),
    .out(dut_out)
  );

  alu_muldiv #(.BIT_WIDTH(8), .MULDIV_EN(1'b1)) dut8 (
    .clk(clk), .rst(rst), .flush(flush8), .in_valid(in_valid8), .in_ready(in_ready8),
    .op(op8), .in1(in1_8), .in2(in2_8), .out_valid(out_valid8), .out_ready(out_ready8),
    .out(out8)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, got, want);
    end
  endtask

  // Reference: RISC-V semantics evaluated with 64-bit integer arithmetic.
  function automatic logic [31:0] model(input int w, input logic [4:0] o,
                                        input logic [31:0] a, input logic [31:0] b);
    longint unsigned ua, ub, mask, r, sh;
    longint sa, sb, minneg;
    logic ovf;
    mask   = (64'd1 << w) - 1;
    ua     = {32'd0, a} & mask;
    ub     = {32'd0, b} & mask;
    sa     = longint'(ua);
    sb     = longint'(ub);
    if (((ua >> (w - 1)) & 1) != 0) sa = sa - longint'(mask) - 1;
    if (((ub >> (w - 1)) & 1) != 0) sb = sb - longint'(mask) - 1;
    minneg = -(longint'(1) << (w - 1));
    ovf    = (sa == minneg) && (sb == -1);
    sh     = ub % longint'(w);
    case (o)
      5'h00: r = ua + ub;
      5'h01: r = ua - ub;
      5'h02: r = (sa < sb) ? 1 : 0;
      5'h03: r = (ua < ub) ? 1 : 0;
      5'h04: r = ua & ub;
      5'h05: r = ua | ub;
      5'h06: r = ua ^ ub;
      5'h07: r = ua << sh;
      5'h08: r = ua >> sh;
      5'h09: r = longint'(sa >>> sh);
      5'h10: r = sa * sb;
      5'h11: r = (sa * sb) >>> w;
      5'h12: r = (sa * longint'(ub)) >>> w;
      5'h13: r = (ua * ub) >> w;
      5'h14: r = (ub == 0) ? mask : (ovf ? ua : longint'(sa / sb));
      5'h15: r = (ub == 0) ? mask : ua / ub;
      5'h16: r = (ub == 0) ? ua : (ovf ? 0 : longint'(sa % sb));
      5'h17: r = (ub == 0) ? ua : ua % ub;
      default: r = 0;
    endcase
    r = r & mask;
    return r[31:0];
  endfunction

  // Edges after the accepting edge until out_valid is seen.
  function automatic int exp_lat(input int w, input logic [4:0] o,
                                 input logic [31:0] a, input logic [31:0] b);
    logic [31:0] m;
    m = (w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 1);
    if (o[4:3] != 2'b10) return 0;
    if (o[2]) begin
      if ((b & m) == 0) return 0;
      if (!o[0] && ((a & m) == (32'd1 << (w - 1))) && ((b & m) == m)) return 0;
    end
    return w + 1;
  endfunction

  function automatic logic [31:0] pick(input int w);
    logic [31:0] m;
    m = (w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 1);
    case ($urandom_range(0, 7))
      0: return 32'd0;
      1: return 32'd1;
      2: return m;
      3: return 32'd1 << (w - 1);
      4: return m >> 1;
      default: return $urandom & m;
    endcase
  endfunction

  function automatic logic [4:0] pick_op();
    int r;
    r = $urandom_range(0, 9);
    if (r < 6) return 5'h10 + 5'($urandom_range(0, 7));
    if (r < 9) return 5'($urandom_range(0, 9));
    return 5'($urandom_range(10, 15));
  endfunction

  task automatic do_op32(input logic [4:0] o, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] want, input int hold);
    int k;
    @(negedge clk);
    op = o; in1 = a; in2 = b; in_valid = 1'b1;
    chk("rdy_idle", in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0; op = 5'($urandom); in1 = $urandom; in2 = $urandom;
    k = 0;
    while (!out_valid && k < 100) begin
      @(posedge clk); #1;
      k++;
    end
    chk("latency", k, exp_lat(32, o, a, b));
    chk("result", dut_out, want);
    chk("rdy_busy", in_ready, 0);
    $display("w32 op=%02h in1=%h in2=%h out=%h want=%h edges=%0d", o, a, b, dut_out, want, k);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      chk("hold_out", dut_out, want);
      chk("hold_valid", out_valid, 1);
      chk("hold_rdy", in_ready, 0);
    end
    @(negedge clk); out_ready = 1'b1;
    @(posedge clk); #1; out_ready = 1'b0;
    chk("rdy_after", in_ready, 1);
    chk("valid_drop", out_valid, 0);
  endtask

  task automatic do_op8(input logic [4:0] o, input logic [7:0] a, input logic [7:0] b);
    int k;
    logic [31:0] want;
    want = model(8, o, {24'd0, a}, {24'd0, b});
    @(negedge clk);
    op8 = o; in1_8 = a; in2_8 = b; in_valid8 = 1'b1;
    @(posedge clk); #1;
    in_valid8 = 1'b0; op8 = 5'($urandom); in1_8 = 8'($urandom); in2_8 = 8'($urandom);
    k = 0;
    while (!out_valid8 && k < 40) begin
      @(posedge clk); #1;
      k++;
    end
    chk("lat8", k, exp_lat(8, o, {24'd0, a}, {24'd0, b}));
    chk("result8", {24'd0, out8}, want);
    $display("w8  op=%02h in1=%h in2=%h out=%h want=%h edges=%0d", o, a, b, out8, want[7:0], k);
    @(negedge clk); out_ready8 = 1'b1;
    @(posedge clk); #1; out_ready8 = 1'b0;
    chk("rdy8_after", in_ready8, 1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [4:0]  o;
    logic [31:0] a, b;
    int k;
    logic seen;

    #12;
    chk("rst_ready", in_ready, 1);
    chk("rst_valid", out_valid, 0);
    chk("rst_out", dut_out, 0);
    @(negedge clk); rst = 1'b0;

    // Directed cases.
    do_op32(OP_ADD,    32'h7FFF_FFFF, 32'd1,         32'h8000_0000, 0);
    do_op32(OP_SUB,    32'd5,         32'd7,         32'hFFFF_FFFE, 0);
    do_op32(OP_SRA,    32'h8000_0000, 32'd4,         32'hF800_0000, 0);
    do_op32(OP_MULH,   32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 0);
    do_op32(OP_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    do_op32(OP_DIV,    32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 0);
    do_op32(OP_REM,    32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 0);
    do_op32(OP_DIVU,   32'd7,         32'd0,         32'hFFFF_FFFF, 0);
    do_op32(OP_REMU,   32'd7,         32'd0,         32'd7,         0);
    do_op32(OP_DIV,    32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 0);
    do_op32(OP_REM,    32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         0);
    do_op32(5'h0C,     32'd3,         32'd4,         32'd0,         0);
    do_op32(OP_MUL,    32'd12345,     32'hFFFF_FFFD, model(32, OP_MUL, 32'd12345, 32'hFFFF_FFFD), 10);

    // Flush during the fifth CALC cycle.
    @(negedge clk); op = OP_MUL; in1 = 32'd123; in2 = 32'd456; in_valid = 1'b1;
    @(posedge clk); #1; in_valid = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk); flush = 1'b1;
    @(posedge clk); #1; flush = 1'b0;
    chk("flush_ready", in_ready, 1);
    chk("flush_valid", out_valid, 0);
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (out_valid) seen = 1'b1;
    end
    chk("flush_novalid", seen, 0);

    // Flush together with out_ready in DONE drops the result.
    @(negedge clk); op = OP_ADD; in1 = 32'd3; in2 = 32'd4; in_valid = 1'b1;
    @(posedge clk); #1; in_valid = 1'b0;
    chk("done_valid", out_valid, 1);
    @(negedge clk); flush = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1; flush = 1'b0; out_ready = 1'b0;
    chk("flushdone_valid", out_valid, 0);
    chk("flushdone_ready", in_ready, 1);

    // Asynchronous reset in the middle of CALC.
    @(negedge clk); op = OP_DIV; in1 = 32'd1000; in2 = 32'd7; in_valid = 1'b1;
    @(posedge clk); #1; in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #3; rst = 1'b1; #1;
    chk("arst_ready", in_ready, 1);
    chk("arst_valid", out_valid, 0);
    chk("arst_out", dut_out, 0);
    @(negedge clk); rst = 1'b0;
    do_op32(OP_ADD, 32'd1, 32'd1, 32'd2, 0);

    // Random traffic at both widths.
    for (int n = 0; n < 60; n++) begin
      o = pick_op();
      a = pick(32);
      b = pick(32);
      if (o >= OP_SLL && o <= OP_SRA && $urandom_range(0, 1) == 1) b = 32'($urandom_range(0, 31));
      do_op32(o, a, b, model(32, o, a, b), $urandom_range(0, 2));
    end
    for (int n = 0; n < 60; n++) begin
      o = pick_op();
      a = pick(8);
      b = pick(8);
      do_op8(o, a[7:0], b[7:0]);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
